// File: rtl/decade_disp_pkg.sv
// Shared types and seven-segment encodings (active-high, bit order gfedcba)
// for the decade display driver.
`timescale 1ns/1ps
package decade_disp_pkg;
  typedef logic [3:0] bcd_t;

  localparam int DEFAULT_NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder (active-high gfedcba).
// Codes 10..15 decode to a blank digit.
`timescale 1ns/1ps
module bcd_to_seg7
  import decade_disp_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/decade_display_driver.sv
// Extends a BCD ones digit into a multi-digit decade count and scans it onto a
// common-anode 7-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
`timescale 1ns/1ps
module decade_display_driver
  import decade_disp_pkg::*;
#(
  parameter int NUM_DIGITS     = DEFAULT_NUM_DIGITS,
  parameter int REFRESH_DIV    = 1000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              ones_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    overflow
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic                  LOW    = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF = LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = LOW ? {NUM_DIGITS{1'b1}} : '0;

  logic [3:0]            prev_ones;
  logic [3:0]            ones_q;
  bcd_t                  upper [1:NUM_DIGITS-1];
  logic [CNT_W-1:0]      refresh_cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic                  out_en;
  logic                  wrap;
  logic                  all_nine;
  logic [NUM_DIGITS-1:1] inc;
  logic                  blank;
  bcd_t                  sel_val;
  bcd_t                  dec_in;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] one_hot;

  assign wrap = (prev_ones == 4'd9) && (ones_in == 4'd0);

  // Synchronous carry chain: digit k steps when every lower upper digit is 9.
  always_comb begin
    inc    = '0;
    inc[1] = wrap;
    for (int k = 2; k < NUM_DIGITS; k++)
      inc[k] = inc[k-1] && (upper[k-1] == 4'd9);
  end

  assign all_nine = inc[NUM_DIGITS-1] && (upper[NUM_DIGITS-1] == 4'd9);

  always_comb begin
    digits      = '0;
    digits[3:0] = ones_q;
    for (int k = 1; k < NUM_DIGITS; k++)
      digits[4*k +: 4] = upper[k];
  end

  assign sel_val = digits[4*int'(digit_idx) +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS:1] lz;
  always_comb begin
    lz             = '0;
    lz[NUM_DIGITS] = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--)
      lz[k] = lz[k+1] && (upper[k] == 4'd0);
  end
  assign blank = (digit_idx != '0) && lz[int'(digit_idx)];
`else
  assign blank = 1'b0;
`endif

  // Forcing an invalid code makes the decoder emit its blank pattern.
  assign dec_in  = blank ? 4'hF : sel_val;
  assign one_hot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx;

  bcd_to_seg7 u_dec (
    .bcd (dec_in),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ones   <= '0;
      ones_q      <= '0;
      overflow    <= 1'b0;
      refresh_cnt <= '0;
      digit_idx   <= '0;
      out_en      <= 1'b0;
      seg         <= SEG_OFF;
      an          <= AN_OFF;
      for (int k = 1; k < NUM_DIGITS; k++) upper[k] <= '0;
    end else begin
      prev_ones <= ones_in;
      ones_q    <= ones_in;
      for (int k = 1; k < NUM_DIGITS; k++)
        if (inc[k]) upper[k] <= (upper[k] == 4'd9) ? 4'd0 : upper[k] + 4'd1;
      if (all_nine) overflow <= 1'b1;

      if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        digit_idx   <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end

      // Pins stay dark for the first cycle out of reset, then follow the scan.
      out_en <= 1'b1;
      if (out_en) begin
        seg <= LOW ? ~dec_seg : dec_seg;
        an  <= LOW ? ~one_hot : one_hot;
      end
    end
  end
endmodule

// File: tb/tb_decade_display_driver.sv
// Bench for decade_display_driver: directed steps plus random ones_in, checked
// against a counting model of the displayed decade value.
`timescale 1ns/1ps
module tb_decade_display_driver;
  localparam int ND = 4;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    ones_in = 4'd0;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic [4*ND-1:0] digits;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  // reference model state
  int         upper_cnt = 0;
  int         m_prev = 0;
  int         m_ones = 0;
  int         n = 0;
  bit         m_ovf = 1'b0;
  logic [6:0] m_seg = 7'h7F;
  logic [3:0] m_an  = 4'hF;
  logic [6:0] seg_tab [16];

  decade_display_driver #(
    .NUM_DIGITS     (ND),
    .REFRESH_DIV    (RD),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ones_in  (ones_in),
    .seg      (seg),
    .an       (an),
    .digits   (digits),
    .overflow (overflow)
  );

  always #50 clk = ~clk;

  function automatic int pow10(input int e);
    int p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  function automatic int digit_of(input int idx);
    if (idx == 0) return m_ones;
    return (upper_cnt / pow10(idx - 1)) % 10;
  endfunction

  function automatic logic [15:0] model_digits();
    logic [15:0] d = '0;
    for (int i = 0; i < ND; i++) d[4*i +: 4] = 4'(digit_of(i));
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int v, input bit r);
    int  idx;
    bit  blank;
    if (r) begin
      upper_cnt = 0; m_prev = 0; m_ones = 0; n = 0; m_ovf = 1'b0;
      m_seg = 7'h7F; m_an = 4'hF;
      return;
    end
    if (n >= 1) begin
      idx   = (n / RD) % ND;
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (idx > 0 && (upper_cnt / pow10(idx - 1)) == 0) blank = 1'b1;
`endif
      m_an  = ~(4'b0001 << idx);
      m_seg = blank ? 7'h7F : ~seg_tab[digit_of(idx)];
    end
    if (m_prev == 9 && v == 0) begin
      upper_cnt++;
      if (upper_cnt == pow10(ND - 1)) begin
        upper_cnt = 0;
        m_ovf = 1'b1;
      end
    end
    m_prev = v;
    m_ones = v;
    n++;
  endtask

  task automatic check_all();
    chk("seg", 32'(seg), 32'(m_seg));
    chk("an", 32'(an), 32'(m_an));
    chk("digits", 32'(digits), 32'(model_digits()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic step(input logic [3:0] v, input logic r);
    ones_in = v;
    rst     = r;
    @(posedge clk);
    model_edge(int'(v), r);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_wraps(input int count);
    for (int i = 0; i < count; i++) begin
      step(4'd9, 1'b0);
      step(4'd0, 1'b0);
    end
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

    // reset for two edges
    step(4'd0, 1'b1);
    step(4'd0, 1'b1);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    step(4'd0, 1'b0);
    chk("first_an_off", 32'(an), 32'hF);
    chk("first_seg_off", 32'(seg), 32'h7F);
    step(4'd0, 1'b0);
    chk("second_an", 32'(an), 32'hE);
    chk("second_seg", 32'(seg), 32'h40);

    // single wrap 0..9 then 0
    for (int i = 0; i <= 9; i++) step(4'(i), 1'b0);
    step(4'd0, 1'b0);
    chk("single_wrap", 32'(digits), 32'h0010);

    // invalid input: 9 -> C -> 0 gives no carry; hold C through a digit-0 scan
    step(4'd9, 1'b0);
    for (int i = 0; i < 2 * ND * RD; i++) step(4'hC, 1'b0);
    step(4'd0, 1'b0);
    chk("invalid_no_carry", 32'(digits), 32'h0010);

    // cascade to 9990 then overflow
    step(4'd0, 1'b1);
    do_wraps(999);
    chk("preload_9990", 32'(digits), 32'h9990);
    step(4'd9, 1'b0);
    step(4'd0, 1'b0);
    chk("ovf_digits", 32'(digits), 32'h0000);
    chk("ovf_flag", 32'(overflow), 32'h1);
    for (int i = 0; i < 8; i++) step(4'($urandom_range(0, 8)), 1'b0);
    chk("ovf_sticky", 32'(overflow), 32'h1);

    // scan order on 1234
    step(4'd0, 1'b1);
    do_wraps(123);
    for (int i = 0; i < 3 * ND * RD; i++) step(4'd4, 1'b0);
    chk("scan_digits", 32'(digits), 32'h1234);

    // reset in the same cycle as a 9->0 wrap
    step(4'd9, 1'b0);
    step(4'd0, 1'b1);
    chk("rst_wrap_digits", 32'(digits), 32'h0);
    chk("rst_wrap_an", 32'(an), 32'hF);
    step(4'd0, 1'b0);
    chk("rst_wrap_no_carry", 32'(digits), 32'h0);

    // random stimulus, biased toward wraps, with rare resets
    for (int i = 0; i < 1500; i++) begin
      int sel;
      logic [3:0] v;
      sel = int'($urandom_range(0, 99));
      if (sel < 45)      v = (m_prev == 9) ? 4'd0 : 4'd9;
      else               v = 4'($urandom_range(0, 15));
      step(v, ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decade_display_driver.md
Name: decade_display_driver

Overview:
- Downstream consumer of the 4-bit decade counter.
- Takes the counter's BCD ones digit and detects each 9->0 wrap. Each wrap carries into internal tens/hundreds/thousands decade digits.
- Time-multiplexes all digits onto a common-anode 7-segment display.
- Sits between the decade counter and the board display pins.

Parameters:
- NUM_DIGITS, 4, total displayed digits including the ones digit; legal range 2..8.
- REFRESH_DIV, 1000, clk cycles each digit stays selected; minimum 2.
- SEG_ACTIVE_LOW, 1, 1 = seg/an driven active-low; 0 = active-high.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ones_in  in  4  BCD ones digit from the decade counter's out.
- seg  out  7  segment drive, bit order {g,f,e,d,c,b,a}.
- an  out  NUM_DIGITS  digit enable; bit 0 = ones digit.
- digits  out  4*NUM_DIGITS  packed BCD value; [3:0] = ones, [7:4] = tens, ...
- overflow  out  1  sticky flag; upper digits rolled over from all-9.

Behaviour:
- Reset: one clock domain (clk); rst is synchronous and active-high, sampled on the rising clk edge.
  - While rst=1 at an edge, all state clears: prev_ones=0, upper digits=0, refresh_cnt=0, digit_idx=0, overflow=0.
  - seg and an go to all-off (SEG_ACTIVE_LOW=1: seg=7'h7F, an=all ones).
  - digits=0.
- Input capture: prev_ones <= ones_in every cycle.
  - ones_in > 9 is invalid. No carry is generated and the ones digit displays blank.
- Wrap detect: wrap = (prev_ones==9) && (ones_in==0), evaluated combinationally.
  - prev_ones resets to 0, so a 0 on ones_in after reset never produces a false wrap.
- Upper digits (indices 1..NUM_DIGITS-1) form a ripple-free cascaded decade chain updated on the wrap cycle edge.
  - Digit k increments when wrap=1 and digits 1..k-1 are all 9.
  - A digit at 9 that increments goes to 0.
- Overflow: a wrap while all upper digits are 9 clears them all to 0 and sets overflow=1. overflow holds until rst.
- digits output: ones field = ones_in registered (1-cycle latency); upper fields = upper digit registers.
  - An upper digit changes 1 cycle after the wrap edge.
- Scan:
  - refresh_cnt counts 0..REFRESH_DIV-1 and wraps.
  - At terminal count, digit_idx advances modulo NUM_DIGITS: 0,1,...,NUM_DIGITS-1,0.
- Output register (1-cycle latency from digit_idx/value to pins):
  - an = one-hot(digit_idx), inverted if SEG_ACTIVE_LOW.
  - seg = decode(selected digit), inverted if SEG_ACTIVE_LOW.
  - First cycle after rst deassert: an/seg still all-off. The second edge selects digit 0.
- Decode, active-high, gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; 10..15 = 00 (blank).
- Simultaneous events: a wrap and a scan advance in the same cycle are independent. The display shows the new upper value on the next selection of that digit.
- Reset mid-operation: rst has priority over wrap and scan in the same cycle.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: any upper digit that is 0 and has all higher digits 0 displays blank (seg all-off, an still asserted). The ones digit is never blanked.
- Undefined: all digits display their value, including leading zeros.
- digits output is identical in both builds.

Decomposition:
- Shared package decade_disp_pkg:
  - Seg7 encoding constants SEG_0..SEG_9 and SEG_BLANK (active-high gfedcba).
  - Typedef for a 4-bit BCD digit.
  - Default NUM_DIGITS.
- Sub-module bcd_to_seg7: combinational 4-bit -> 7-bit decoder using the package constants; invalid input -> SEG_BLANK.
- Polarity inversion stays in the top level.

Test Plan:
- Bench parameters: REFRESH_DIV=4, NUM_DIGITS=4, SEG_ACTIVE_LOW=1, clk period 100ns.
- Reset: rst=1 for 2 edges with ones_in=0 -> seg=7F, an=F, digits=0, overflow=0. After deassert, second edge -> an=E, seg=40 ('0' inverted).
- Single wrap: drive ones_in 0..9 then 0 -> digits=16'h0010 one cycle after the 0 is sampled.
- Invalid input: ones_in=4'hC -> when digit 0 is selected, seg=7F. 9->C->0 produces no carry (prev_ones=C at the 0).
- Cascade and overflow: preload to 9990 via 999 wraps then drive 9->0 -> digits=16'h0000, overflow=1, held until rst.
- Scan order: hold digits=16'h1234 -> an sequence E,D,B,7, 4 cycles each. seg = 4'h66,4F,5B,06 inverted = 19,30,24,79.
- Reset mid-scan with wrap pending: assert rst in the same cycle as 9->0 -> digits=0, no carry, an=F.
